// File: rtl/parametrik_cift_portlu_bellek.sv
// Simple-dual-port RAM with per-byte write enables, a registered read and a
// hardware clear sequencer that zeroes every word after reset or on request.

module pcpb_bayt_seridi #(
  parameter int ADRES_GENISLIK = 4,
  parameter int BYPASS         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      yaz,
  input  logic [ADRES_GENISLIK-1:0] yaz_adres,
  input  logic [7:0]                yaz_bayt,
  input  logic                      oku,
  input  logic [ADRES_GENISLIK-1:0] oku_adres,
  output logic [7:0]                oku_bayt
);
  localparam int DERINLIK = 1 << ADRES_GENISLIK;

  logic [7:0] mem [DERINLIK];
  logic [7:0] oku_d;

  always_ff @(posedge clk)
    if (yaz) mem[yaz_adres] <= yaz_bayt;

  // Same-address bypass only when this byte is actually being written.
  always_comb begin
    oku_d = mem[oku_adres];
    if (BYPASS != 0 && yaz && yaz_adres == oku_adres) oku_d = yaz_bayt;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   oku_bayt <= '0;
    else if (oku) oku_bayt <= oku_d;
endmodule

module parametrik_cift_portlu_bellek #(
  parameter int VERI_GENISLIK  = 16,
  parameter int ADRES_GENISLIK = 4,
  parameter int BYPASS         = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       temizle,
  input  logic                       yaz_en,
  input  logic [VERI_GENISLIK/8-1:0] yaz_bayt_en,
  input  logic [ADRES_GENISLIK-1:0]  yaz_adres,
  input  logic [VERI_GENISLIK-1:0]   yaz_veri,
  input  logic                       oku_en,
  input  logic [ADRES_GENISLIK-1:0]  oku_adres,
  output logic [VERI_GENISLIK-1:0]   oku_veri,
  output logic                       oku_gecerli,
  output logic                       mesgul
);
  localparam int BAYT_SAYISI = VERI_GENISLIK / 8;
  localparam int DERINLIK    = 1 << ADRES_GENISLIK;

  typedef enum logic {TEMIZLE, HAZIR} durum_t;

  durum_t                    durum, durum_d;
  logic [ADRES_GENISLIK-1:0] sayac;
  logic                      son, hazir, yaz_kul, oku_kul;
  logic [1:0]                vld_pipe;
  logic [BAYT_SAYISI-1:0][7:0] oku_bayt;

  assign son     = (sayac == ADRES_GENISLIK'(DERINLIK - 1));
  assign hazir   = (durum == HAZIR);
  assign mesgul  = ~hazir;
  assign yaz_kul = hazir & yaz_en;
  assign oku_kul = hazir & oku_en;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) durum <= TEMIZLE;
    else        durum <= durum_d;

  always_comb begin
    durum_d = durum;
    case (durum)
      TEMIZLE: if (son)     durum_d = HAZIR;
      HAZIR:   if (temizle) durum_d = TEMIZLE;
      default:              durum_d = TEMIZLE;
    endcase
  end

  // Sweep counter parks at the last address; a new sweep reloads it from 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                        sayac <= '0;
    else if (!hazir && !son)           sayac <= sayac + 1'b1;
    else if (hazir && temizle)         sayac <= '0;

  assign vld_pipe[0] = oku_kul;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  assign oku_gecerli = vld_pipe[1];

  for (genvar i = 0; i < BAYT_SAYISI; i++) begin : g_bayt
    pcpb_bayt_seridi #(
      .ADRES_GENISLIK(ADRES_GENISLIK),
      .BYPASS        (BYPASS)
    ) u_serit (
      .clk      (clk),
      .rst_n    (rst_n),
      .yaz      (~hazir | (yaz_kul & yaz_bayt_en[i])),
      .yaz_adres(hazir ? yaz_adres : sayac),
      .yaz_bayt (hazir ? yaz_veri[i*8 +: 8] : 8'h00),
      .oku      (oku_kul),
      .oku_adres(oku_adres),
      .oku_bayt (oku_bayt[i])
    );
  end

  assign oku_veri = oku_bayt;
endmodule

// File: tb/tb_parametrik_cift_portlu_bellek.sv
// Directed bench: reset/sweep timing, vector table of writes/reads, clear and reset corner cases.

module tb_parametrik_cift_portlu_bellek;
  localparam int VG = 16, AG = 4, BYP = 1;

  logic          clk = 1'b0, rst_n = 1'b0, temizle = 1'b0;
  logic          yaz_en = 1'b0, oku_en = 1'b0;
  logic [1:0]    yaz_bayt_en = '0;
  logic [AG-1:0] yaz_adres = '0, oku_adres = '0;
  logic [VG-1:0] yaz_veri = '0;
  logic [VG-1:0] oku_veri;
  logic          oku_gecerli, mesgul;

  int n_chk = 0, n_fail = 0;

  parametrik_cift_portlu_bellek #(.VERI_GENISLIK(VG), .ADRES_GENISLIK(AG), .BYPASS(BYP)) dut (
    .clk(clk), .rst_n(rst_n), .temizle(temizle), .yaz_en(yaz_en), .yaz_bayt_en(yaz_bayt_en),
    .yaz_adres(yaz_adres), .yaz_veri(yaz_veri), .oku_en(oku_en), .oku_adres(oku_adres),
    .oku_veri(oku_veri), .oku_gecerli(oku_gecerli), .mesgul(mesgul)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [1:0]    be;
    logic [AG-1:0] wa;
    logic [VG-1:0] wd;
    logic          re;
    logic [AG-1:0] ra;
    logic          exp_vld;
    logic          chk_data;
    logic [VG-1:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    yaz_en = 0; oku_en = 0; temizle = 0; yaz_bayt_en = '0;
  endtask

  task automatic wait_sweep(input string name, input int exp_edges);
    int n = 0;
    while (mesgul && n < 100) begin step(); n++; end
    chk(name, n, exp_edges);
  endtask

  task automatic wr(input logic [AG-1:0] a, input logic [VG-1:0] d);
    yaz_en = 1; yaz_bayt_en = 2'b11; yaz_adres = a; yaz_veri = d; step(); idle();
  endtask

  task automatic rd_chk(input string name, input logic [AG-1:0] a, input logic [VG-1:0] exp);
    oku_en = 1; oku_adres = a; step(); idle();
    chk({name, "_vld"}, oku_gecerli, 1);
    chk(name, oku_veri, exp);
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 16; a++) rd_chk($sformatf("%s_a%0d", name, a), AG'(a), 16'h0000);
  endtask

  initial begin
    // Test 1: reset state and power-up sweep
    #12;
    chk("rst_oku_veri", oku_veri, 0);
    chk("rst_oku_gecerli", oku_gecerli, 0);
    chk("rst_mesgul", mesgul, 1);
    @(posedge clk); #1; rst_n = 1;
    wait_sweep("init_sweep_len", 16);
    read_all_zero("init_zero");

    // Directed vectors: {we,be,wa,wd,re,ra,exp_vld,chk_data,exp_data}
    vecs[0]  = '{1, 2'b11, 4'd3, 16'hA5A5, 0, 4'd0, 0, 0, 16'h0000};
    vecs[1]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd3, 1, 1, 16'hA5A5};
    vecs[2]  = '{1, 2'b11, 4'd5, 16'h1234, 0, 4'd0, 0, 0, 16'h0000};
    vecs[3]  = '{1, 2'b01, 4'd5, 16'hFFFF, 0, 4'd0, 0, 0, 16'h0000};
    vecs[4]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd5, 1, 1, 16'h12FF};
    vecs[5]  = '{1, 2'b00, 4'd5, 16'h0000, 0, 4'd0, 0, 0, 16'h0000};
    vecs[6]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd5, 1, 1, 16'h12FF};
    vecs[7]  = '{1, 2'b11, 4'd7, 16'h1111, 0, 4'd0, 0, 1, 16'h12FF};
    vecs[8]  = '{1, 2'b11, 4'd7, 16'h2222, 1, 4'd7, 1, 1, (BYP != 0) ? 16'h2222 : 16'h1111};
    vecs[9]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd7, 1, 1, 16'h2222};
    vecs[10] = '{0, 2'b00, 4'd0, 16'h0000, 0, 4'd0, 0, 1, 16'h2222};
    vecs[11] = '{1, 2'b01, 4'd7, 16'h33CC, 1, 4'd7, 1, 1, (BYP != 0) ? 16'h22CC : 16'h2222};
    vecs[12] = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd7, 1, 1, 16'h22CC};
    vecs[13] = '{1, 2'b10, 4'd9, 16'h5566, 1, 4'd3, 1, 1, 16'hA5A5};
    vecs[14] = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd9, 1, 1, 16'h5500};
    vecs[15] = '{1, 2'b11, 4'd15, 16'hBEEF, 1, 4'd15, 1, 1, (BYP != 0) ? 16'hBEEF : 16'h0000};

    for (int i = 0; i < 16; i++) begin
      yaz_en = vecs[i].we; yaz_bayt_en = vecs[i].be; yaz_adres = vecs[i].wa; yaz_veri = vecs[i].wd;
      oku_en = vecs[i].re; oku_adres = vecs[i].ra;
      step();
      chk($sformatf("vec%0d_vld", i), oku_gecerli, vecs[i].exp_vld);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), oku_veri, vecs[i].exp_data);
    end
    idle();
    rd_chk("addr15_after", 4'd15, 16'hBEEF);

    // Test 5: fill, clear, ignored ops during sweep, temizle mid-sweep
    for (int a = 0; a < 16; a++) wr(AG'(a), 16'h1000 + 16'(a));
    rd_chk("fill_a2", 4'd2, 16'h1002);
    temizle = 1; step(); temizle = 0;
    chk("clr_mesgul", mesgul, 1);
    begin
      int n = 0;
      int bad_vld = 0, bad_hold = 0;
      while (mesgul && n < 100) begin
        yaz_en = 1; yaz_bayt_en = 2'b11; yaz_adres = 4'd0; yaz_veri = 16'hFFFF;
        oku_en = 1; oku_adres = 4'd4;
        temizle = (n == 5);
        step(); n++;
        if (oku_gecerli !== 1'b0) bad_vld++;
        if (oku_veri !== 16'h1002) bad_hold++;
      end
      idle();
      chk("clr_sweep_len", n, 16);
      chk("clr_no_vld", bad_vld, 0);
      chk("clr_data_hold", bad_hold, 0);
    end
    read_all_zero("clr_zero");

    // Test 6: reset mid-sweep restarts from address 0
    wr(4'd1, 16'hBEEF);
    rd_chk("pre_rst_rd", 4'd1, 16'hBEEF);
    temizle = 1; step(); temizle = 0;
    for (int k = 0; k < 8; k++) step();
    chk("mid_mesgul", mesgul, 1);
    rst_n = 0; #1;
    chk("mid_rst_oku_veri", oku_veri, 0);
    chk("mid_rst_oku_gecerli", oku_gecerli, 0);
    chk("mid_rst_mesgul", mesgul, 1);
    step(); step();
    rst_n = 1;
    wait_sweep("rst_sweep_len", 16);
    read_all_zero("rst_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
